// File: rtl/serial_display_chain_if.sv
// Frame request/handshake and serial-line bundle for serial_display_chain.
interface serial_display_chain_if #(
    parameter int N_DEV  = 1,
    parameter int WORD_W = 16
);
    logic                      i_en;
    logic                      i_valid;
    logic [N_DEV*WORD_W-1:0]   i_data;
    logic                      o_ready;
    logic                      o_serial_clk;
    logic                      o_serial_dout;
    logic                      o_serial_load;
    logic                      o_busy;
    logic                      o_done;

    modport master (
        output i_en, i_valid, i_data,
        input  o_ready, o_serial_clk, o_serial_dout, o_serial_load, o_busy, o_done
    );

    modport slave (
        input  i_en, i_valid, i_data,
        output o_ready, o_serial_clk, o_serial_dout, o_serial_load, o_busy, o_done
    );
endinterface

// File: rtl/serial_display_chain.sv
// Shifts one N_DEV*WORD_W frame into a chain of serial display drivers sharing
// one load line, then pulses load high to latch it.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | load high, SCK low, ready to accept a frame
// SHIFT_LO | SCK low half period, current bit on dout
// SHIFT_HI | SCK high half period, devices sample dout
// HOLD     | SCK low, load still low, one half period after the last bit
// LATCH    | load high for one half period; may chain straight into a new frame
module serial_display_chain #(
    parameter int N_DEV     = 1,
    parameter int WORD_W    = 16,
    parameter int CLK_DIV   = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    serial_display_chain_if.slave bus
);
    localparam int B  = N_DEV * WORD_W;
    localparam int HW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(B + 1);
    localparam logic [HW-1:0] HALF_TC  = HW'(CLK_DIV - 1);
    localparam logic [HW-1:0] HALF_ONE = HW'(1);
    localparam logic [BW-1:0] LAST_BIT = BW'(B - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);

    typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, HOLD, LATCH} state_t;

    state_t          state, state_n;
    logic [HW-1:0]   half_cnt, half_cnt_n;
    logic [BW-1:0]   bit_cnt, bit_cnt_n;
    logic [B-1:0]    shreg, shreg_n, shreg_shifted;
    logic            sck, sck_n, dout, dout_n, load, load_n;
    logic            busy, busy_n, done, done_n, ready, ready_n;
    logic            half_tc, last_bit, accept_idle, accept_chain, load_frame;
    logic            first_bit, next_bit;

    assign half_tc      = (half_cnt == '0);
    assign last_bit     = (bit_cnt == '0);
    assign accept_idle  = bus.i_valid & bus.i_en & ready;
    // Chaining at the end of LATCH keeps load high exactly one half period between frames.
    assign accept_chain = bus.i_valid & bus.i_en;
    assign load_frame   = ((state == IDLE) && accept_idle) ||
                          ((state == LATCH) && half_tc && accept_chain);

    assign first_bit     = MSB_FIRST ? bus.i_data[B-1] : bus.i_data[0];
    assign next_bit      = MSB_FIRST ? shreg[B-2] : shreg[1];
    assign shreg_shifted = MSB_FIRST ? {shreg[B-2:0], 1'b0} : {1'b0, shreg[B-1:1]};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= IDLE;
            half_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            sck      <= 1'b0;
            dout     <= 1'b0;
            load     <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            ready    <= 1'b0;
        end else begin
            state    <= state_n;
            half_cnt <= half_cnt_n;
            bit_cnt  <= bit_cnt_n;
            shreg    <= shreg_n;
            sck      <= sck_n;
            dout     <= dout_n;
            load     <= load_n;
            busy     <= busy_n;
            done     <= done_n;
            ready    <= ready_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (accept_idle) state_n = SHIFT_LO;
            SHIFT_LO: if (half_tc) state_n = SHIFT_HI;
            SHIFT_HI: if (half_tc) state_n = last_bit ? HOLD : SHIFT_LO;
            HOLD:     if (half_tc) state_n = LATCH;
            LATCH:    if (half_tc) state_n = accept_chain ? SHIFT_LO : IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_comb begin
        half_cnt_n = half_cnt;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        sck_n      = sck;
        dout_n     = dout;
        load_n     = load;
        busy_n     = busy;
        ready_n    = ready;
        done_n     = 1'b0;
        if (load_frame) begin
            shreg_n    = bus.i_data;
            dout_n     = first_bit;
            half_cnt_n = HALF_TC;
            bit_cnt_n  = LAST_BIT;
            sck_n      = 1'b0;
            load_n     = 1'b0;
            busy_n     = 1'b1;
            ready_n    = 1'b0;
            done_n     = (state == LATCH);
        end else begin
            case (state)
                IDLE: begin
                    ready_n = 1'b1;
                    busy_n  = 1'b0;
                    load_n  = 1'b1;
                    sck_n   = 1'b0;
                    dout_n  = 1'b0;
                end
                SHIFT_LO: begin
                    if (half_tc) begin
                        sck_n      = 1'b1;
                        half_cnt_n = HALF_TC;
                    end else begin
                        half_cnt_n = half_cnt - HALF_ONE;
                    end
                end
                SHIFT_HI: begin
                    if (half_tc) begin
                        sck_n      = 1'b0;
                        half_cnt_n = HALF_TC;
                        if (!last_bit) begin
                            shreg_n   = shreg_shifted;
                            dout_n    = next_bit;
                            bit_cnt_n = bit_cnt - BIT_ONE;
                        end
                    end else begin
                        half_cnt_n = half_cnt - HALF_ONE;
                    end
                end
                HOLD: begin
                    if (half_tc) begin
                        load_n     = 1'b1;
                        half_cnt_n = HALF_TC;
                    end else begin
                        half_cnt_n = half_cnt - HALF_ONE;
                    end
                end
                LATCH: begin
                    if (half_tc) begin
                        ready_n    = 1'b1;
                        busy_n     = 1'b0;
                        done_n     = 1'b1;
                        dout_n     = 1'b0;
                        half_cnt_n = '0;
                    end else begin
                        half_cnt_n = half_cnt - HALF_ONE;
                    end
                end
                default: begin
                    load_n = 1'b1;
                    sck_n  = 1'b0;
                end
            endcase
        end
    end

    assign bus.o_ready       = ready;
    assign bus.o_serial_clk  = sck;
    assign bus.o_serial_dout = dout;
    assign bus.o_serial_load = load;
    assign bus.o_busy        = busy;
    assign bus.o_done        = done;
endmodule

// File: tb/tb_serial_display_chain.sv
// Directed bench for serial_display_chain across four parameter sets.
module tb_serial_display_chain;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_display_chain_if #(.N_DEV(1), .WORD_W(16)) i1();
    serial_display_chain_if #(.N_DEV(2), .WORD_W(16)) i2();
    serial_display_chain_if #(.N_DEV(1), .WORD_W(8))  i3();
    serial_display_chain_if #(.N_DEV(1), .WORD_W(8))  i4();

    serial_display_chain #(.N_DEV(1), .WORD_W(16), .CLK_DIV(1), .MSB_FIRST(1'b1))
        u1 (.i_clk(clk), .i_reset(rst), .bus(i1));
    serial_display_chain #(.N_DEV(2), .WORD_W(16), .CLK_DIV(2), .MSB_FIRST(1'b1))
        u2 (.i_clk(clk), .i_reset(rst), .bus(i2));
    serial_display_chain #(.N_DEV(1), .WORD_W(8), .CLK_DIV(1), .MSB_FIRST(1'b0))
        u3 (.i_clk(clk), .i_reset(rst), .bus(i3));
    serial_display_chain #(.N_DEV(1), .WORD_W(8), .CLK_DIV(3), .MSB_FIRST(1'b1))
        u4 (.i_clk(clk), .i_reset(rst), .bus(i4));

    // Serial-line monitor: one slot per instance, sampled on the falling clock edge.
    logic [3:0] m_sck, m_dout, m_load, m_done;
    logic [3:0] prev_sck = 4'h0;
    logic [3:0] prev_load = 4'hF;
    int rises[4] = '{default: 0};
    int dones[4] = '{default: 0};
    int lowcyc[4] = '{default: 0};
    int done_cyc[4] = '{default: 0};
    int hi_run[4] = '{default: 0};
    int last_hi_run[4] = '{default: 0};
    int bad_sck[4] = '{default: 0};
    logic [63:0] hist[4] = '{default: 64'd0};

    assign m_sck  = {i4.o_serial_clk,  i3.o_serial_clk,  i2.o_serial_clk,  i1.o_serial_clk};
    assign m_dout = {i4.o_serial_dout, i3.o_serial_dout, i2.o_serial_dout, i1.o_serial_dout};
    assign m_load = {i4.o_serial_load, i3.o_serial_load, i2.o_serial_load, i1.o_serial_load};
    assign m_done = {i4.o_done,        i3.o_done,        i2.o_done,        i1.o_done};

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (m_sck[k] === 1'b1 && prev_sck[k] !== 1'b1) begin
                rises[k]++;
                hist[k] = {hist[k][62:0], m_dout[k]};
                if (m_load[k] === 1'b1) bad_sck[k]++;
            end
            if (m_load[k] === 1'b0) begin
                if (prev_load[k] === 1'b1) last_hi_run[k] = hi_run[k];
                hi_run[k] = 0;
                lowcyc[k]++;
            end else begin
                hi_run[k]++;
            end
            if (m_done[k] === 1'b1) begin
                dones[k]++;
                done_cyc[k] = cyc;
            end
        end
        prev_sck  = m_sck;
        prev_load = m_load;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int k, input int target, input string tag);
        for (int i = 0; i < 400 && dones[k] < target; i++) tick();
        chk(tag, 64'(dones[k] >= target), 64'd1);
    endtask

    int e0, r0, l0, d0, b0;

    initial begin
        i1.i_en = 1'b1; i1.i_valid = 1'b0; i1.i_data = '0;
        i2.i_en = 1'b1; i2.i_valid = 1'b0; i2.i_data = '0;
        i3.i_en = 1'b1; i3.i_valid = 1'b0; i3.i_data = '0;
        i4.i_en = 1'b1; i4.i_valid = 1'b0; i4.i_data = '0;
        repeat (3) tick();

        // reset values while reset is held
        chk("rst_load",  64'(i1.o_serial_load), 64'd1);
        chk("rst_sck",   64'(i1.o_serial_clk),  64'd0);
        chk("rst_dout",  64'(i1.o_serial_dout), 64'd0);
        chk("rst_busy",  64'(i1.o_busy),        64'd0);
        chk("rst_done",  64'(i1.o_done),        64'd0);
        chk("rst_ready", 64'(i1.o_ready),       64'd0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst",  64'(i1.o_ready), 64'd1);
        chk("ready_after_rst2", 64'(i2.o_ready), 64'd1);

        // 16-bit MSB-first frame, D=1
        i1.i_data = 16'h0C01; i1.i_valid = 1'b1;
        r0 = rises[0]; l0 = lowcyc[0]; d0 = dones[0];
        tick();
        e0 = cyc;
        i1.i_valid = 1'b0; i1.i_data = 16'hFFFF;
        chk("a_busy",  64'(i1.o_busy),        64'd1);
        chk("a_ready", 64'(i1.o_ready),       64'd0);
        chk("a_load",  64'(i1.o_serial_load), 64'd0);
        chk("a_sck",   64'(i1.o_serial_clk),  64'd0);
        chk("a_dout0", 64'(i1.o_serial_dout), 64'd0);
        wait_done(0, d0 + 1, "a_done_timeout");
        chk("a_done_time", 64'(done_cyc[0] - e0), 64'd34);
        chk("a_rises",     64'(rises[0] - r0),    64'd16);
        chk("a_bits",      hist[0][15:0],         64'h0C01);
        chk("a_load_low",  64'(lowcyc[0] - l0),   64'd33);
        chk("a_ready_end", 64'(i1.o_ready),       64'd1);
        chk("a_busy_end",  64'(i1.o_busy),        64'd0);
        chk("a_dout_idle", 64'(i1.o_serial_dout), 64'd0);
        tick();
        chk("a_done_1cyc", 64'(i1.o_done), 64'd0);

        // two-device 32-bit frame, D=2
        i2.i_data = 32'h0A0F_0B07; i2.i_valid = 1'b1;
        r0 = rises[1]; l0 = lowcyc[1]; d0 = dones[1];
        tick();
        e0 = cyc;
        i2.i_valid = 1'b0;
        chk("b_dout0", 64'(i2.o_serial_dout), 64'd0);
        wait_done(1, d0 + 1, "b_done_timeout");
        chk("b_done_time", 64'(done_cyc[1] - e0), 64'd132);
        chk("b_rises",     64'(rises[1] - r0),    64'd32);
        chk("b_first16",   hist[1][31:16],        64'h0A0F);
        chk("b_bits",      hist[1][31:0],         64'h0A0F_0B07);
        chk("b_load_low",  64'(lowcyc[1] - l0),   64'd130);

        // LSB-first 8-bit frames, D=1
        i3.i_data = 8'h81; i3.i_valid = 1'b1;
        d0 = dones[2]; l0 = lowcyc[2];
        tick();
        e0 = cyc;
        i3.i_valid = 1'b0;
        chk("c1_dout0", 64'(i3.o_serial_dout), 64'd1);
        wait_done(2, d0 + 1, "c1_done_timeout");
        chk("c1_done_time", 64'(done_cyc[2] - e0), 64'd18);
        chk("c1_bits",      hist[2][7:0],          64'h81);
        chk("c1_load_low",  64'(lowcyc[2] - l0),   64'd17);
        i3.i_data = 8'h01; i3.i_valid = 1'b1;
        tick();
        e0 = cyc;
        i3.i_valid = 1'b0;
        wait_done(2, d0 + 2, "c2_done_timeout");
        chk("c2_done_time", 64'(done_cyc[2] - e0), 64'd18);
        chk("c2_bits",      hist[2][7:0],          64'h80);

        // back-to-back frames with valid held, D=3
        i4.i_data = 8'h3C; i4.i_valid = 1'b1;
        r0 = rises[3]; l0 = lowcyc[3]; d0 = dones[3]; b0 = bad_sck[3];
        tick();
        e0 = cyc;
        i4.i_data = 8'hC3;
        wait_done(3, d0 + 1, "d1_done_timeout");
        chk("d1_done_time", 64'(done_cyc[3] - e0), 64'd54);
        chk("d_chain_busy", 64'(i4.o_busy),        64'd1);
        chk("d_chain_load", 64'(i4.o_serial_load), 64'd0);
        chk("d_chain_rdy",  64'(i4.o_ready),       64'd0);
        i4.i_valid = 1'b0;
        wait_done(3, d0 + 2, "d2_done_timeout");
        chk("d2_done_time", 64'(done_cyc[3] - e0), 64'd108);
        chk("d_rises",      64'(rises[3] - r0),    64'd16);
        chk("d_bits",       hist[3][15:0],         64'h3CC3);
        chk("d_gap_high",   64'(last_hi_run[3]),   64'd3);
        chk("d_sck_in_gap", 64'(bad_sck[3] - b0),  64'd0);
        chk("d_load_low",   64'(lowcyc[3] - l0),   64'd102);
        tick();
        chk("d_done_count", 64'(dones[3] - d0), 64'd2);

        // enable low blocks acceptance; dropping it mid-frame does not abort
        i1.i_data = 16'hA5C3; i1.i_en = 1'b0; i1.i_valid = 1'b1;
        l0 = lowcyc[0]; d0 = dones[0]; r0 = rises[0];
        repeat (10) tick();
        chk("e_blocked_load", 64'(i1.o_serial_load), 64'd1);
        chk("e_blocked_busy", 64'(i1.o_busy),        64'd0);
        chk("e_blocked_low",  64'(lowcyc[0] - l0),   64'd0);
        i1.i_en = 1'b1;
        tick();
        e0 = cyc;
        i1.i_en = 1'b0; i1.i_data = 16'h0000;
        chk("e_accepted", 64'(i1.o_busy), 64'd1);
        wait_done(0, d0 + 1, "e_done_timeout");
        chk("e_done_time", 64'(done_cyc[0] - e0), 64'd34);
        chk("e_bits",      hist[0][15:0],         64'hA5C3);
        chk("e_rises",     64'(rises[0] - r0),    64'd16);
        repeat (5) tick();
        chk("e_no_reaccept", 64'(i1.o_busy),      64'd0);
        chk("e_done_count",  64'(dones[0] - d0),  64'd1);
        i1.i_valid = 1'b0; i1.i_en = 1'b1;

        // reset sampled at E0+10 aborts the frame
        i1.i_data = 16'hFFFF; i1.i_valid = 1'b1;
        d0 = dones[0];
        tick();
        e0 = cyc;
        i1.i_valid = 1'b0;
        chk("f_dout0", 64'(i1.o_serial_dout), 64'd1);
        repeat (9) tick();
        chk("f_in_flight", 64'(i1.o_busy), 64'd1);
        rst = 1'b1;
        tick();
        chk("f_rst_edge", 64'(cyc - e0), 64'd10);
        chk("f_load",  64'(i1.o_serial_load), 64'd1);
        chk("f_sck",   64'(i1.o_serial_clk),  64'd0);
        chk("f_dout",  64'(i1.o_serial_dout), 64'd0);
        chk("f_busy",  64'(i1.o_busy),        64'd0);
        chk("f_ready", 64'(i1.o_ready),       64'd0);
        rst = 1'b0;
        r0 = rises[0];
        tick();
        chk("f_ready_rel", 64'(i1.o_ready), 64'd1);
        repeat (40) tick();
        chk("f_no_done", 64'(dones[0] - d0), 64'd0);
        chk("f_no_sck",  64'(rises[0] - r0), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
